// File: rtl/hazard_ctrl_pkg.sv
// Shared register-class encoding and hazard scheduler types.
// The forwarding unit imports the same class constants.
package hazard_ctrl_pkg;
  localparam int REG_W       = 4;
  localparam int FPU_LAT_DEF = 4;

  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_INT  = 2'd1,
    CLS_FP   = 2'd2,
    CLS_PRED = 2'd3
  } reg_cls_e;

  typedef struct packed {
    logic [REG_W-1:0] idx;
    reg_cls_e         cls;
  } src_t;

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] dst;
  } pend_t;
endpackage

// File: rtl/hazard_match.sv
// Compares one ID source operand against one pending destination.
// A source only matches when its class is the class the tracker produces.
module hazard_match
  import hazard_ctrl_pkg::*;
(
  input  src_t     src,
  input  reg_cls_e want,
  input  pend_t    pend,
  output logic     hit
);
  assign hit = pend.v && (src.cls == want) && (src.idx == pend.dst);
endmodule

// File: rtl/hazard_ctrl.sv
// ID-stage hazard scheduler: load-use, FPU RAW/WAW/structural stalls and
// branch flush; drives stall/bubble/flush into IF/ID/EX.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int FPU_LAT = FPU_LAT_DEF,
  parameter int PERF_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_y,
  input  logic [1:0]        id_y_cls,
  input  logic [REG_W-1:0]  id_x,
  input  logic [1:0]        id_x_cls,
  input  logic [REG_W-1:0]  id_z,
  input  logic [1:0]        id_z_cls,
  input  logic              id_ld,
  input  logic              id_fpu,
  input  logic              br_taken,
  output logic              stall,
  output logic              bubble,
  output logic              flush,
  output logic              fpu_busy,
  output logic [PERF_W-1:0] stall_cnt
);
  localparam int NUM_CMP = 4;

  logic              ld_v;
  logic [REG_W-1:0]  ld_dst;
  logic [3:0]        fpu_cnt;
  logic [REG_W-1:0]  fpu_dst;
  logic [PERF_W-1:0] cnt_q;

  src_t  [1:0]         srcs;
  pend_t               ld_pend, fp_pend;
  logic  [NUM_CMP-1:0] hit;
  logic                fpu_gt1;
  logic                luse, fraw, fstr, waw;
  logic                stall_raw, issue;

  // At fpu_cnt == 1 the result is forwardable, so only counts above 1 block.
  assign fpu_gt1 = (fpu_cnt > 4'd1);
  assign srcs[0] = {id_y, reg_cls_e'(id_y_cls)};
  assign srcs[1] = {id_x, reg_cls_e'(id_x_cls)};
  assign ld_pend = '{v: ld_v,    dst: ld_dst};
  assign fp_pend = '{v: fpu_gt1, dst: fpu_dst};

  // hit[1:0]: y/x vs load dest; hit[3:2]: y/x vs FPU dest
  for (genvar g = 0; g < NUM_CMP; g++) begin : g_match
    hazard_match u_match (
      .src  (srcs[g % 2]),
      .want ((g < 2) ? CLS_INT : CLS_FP),
      .pend ((g < 2) ? ld_pend : fp_pend),
      .hit  (hit[g])
    );
  end

  assign luse = id_valid && (hit[0] || hit[1]);
  assign fraw = id_valid && (hit[2] || hit[3]);
  assign fstr = id_valid && id_fpu && fpu_gt1;
  assign waw  = id_valid && fpu_gt1 && (reg_cls_e'(id_z_cls) == CLS_FP) &&
                (id_z == fpu_dst);

  // Flush outranks every stall: the ID instruction is dead anyway.
  assign stall_raw = (luse || fraw || fstr || waw) && !br_taken;
  assign issue     = id_valid && !stall_raw && !br_taken;

  assign stall     = !rst && stall_raw;
  assign flush     = !rst && br_taken;
  assign bubble    = !rst && (stall_raw || br_taken);
  assign fpu_busy  = !rst && (fpu_cnt != 4'd0);
  assign stall_cnt = rst ? '0 : cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_v    <= 1'b0;
      ld_dst  <= '0;
      fpu_cnt <= '0;
      fpu_dst <= '0;
      cnt_q   <= '0;
    end else begin
      // A stall/flush puts a bubble in EX, so any older load has moved on.
      ld_v <= issue && id_ld;
      if (issue && id_ld) ld_dst <= id_z;

      if (issue && id_fpu) begin
        fpu_cnt <= 4'(FPU_LAT);
        fpu_dst <= id_z;
      end else if (fpu_cnt != 4'd0) begin
        fpu_cnt <= fpu_cnt - 4'd1;
      end

      if (stall_raw && (cnt_q != {PERF_W{1'b1}})) cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus a randomized
// run against a cycle-timestamp reference model.
module tb_hazard_ctrl;
  localparam int LAT  = 4;
  localparam int PW   = 4;
  localparam int CMAX = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          id_valid = 1'b0;
  logic [3:0]    id_y = '0, id_x = '0, id_z = '0;
  logic [1:0]    id_y_cls = '0, id_x_cls = '0, id_z_cls = '0;
  logic          id_ld = 1'b0, id_fpu = 1'b0, br_taken = 1'b0;
  logic          stall, bubble, flush, fpu_busy;
  logic [PW-1:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  hazard_ctrl #(.FPU_LAT(LAT), .PERF_W(PW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_y(id_y), .id_y_cls(id_y_cls), .id_x(id_x), .id_x_cls(id_x_cls),
    .id_z(id_z), .id_z_cls(id_z_cls), .id_ld(id_ld), .id_fpu(id_fpu),
    .br_taken(br_taken), .stall(stall), .bubble(bubble), .flush(flush),
    .fpu_busy(fpu_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: remembers the cycle in which the last load / FPU op
  // issued and derives hazards from elapsed time.
  int         mt = 0;
  int         m_ld_t = -100, m_fp_t = -100;
  logic [3:0] m_ld_z = '0, m_fp_z = '0;
  int         m_cnt = 0;
  logic       m_stall, m_bubble, m_flush, m_busy, m_issue;

  task automatic model_eval;
    bit ldp, fgt1, luse, fraw, fstr, waw;
    ldp    = (mt == m_ld_t + 1);
    fgt1   = (m_fp_t >= 0) && (mt - m_fp_t < LAT);
    m_busy = (m_fp_t >= 0) && (mt - m_fp_t <= LAT);
    luse = id_valid && ldp && ((id_y_cls == 2'd1 && id_y == m_ld_z) ||
                               (id_x_cls == 2'd1 && id_x == m_ld_z));
    fraw = id_valid && fgt1 && ((id_y_cls == 2'd2 && id_y == m_fp_z) ||
                                (id_x_cls == 2'd2 && id_x == m_fp_z));
    fstr = id_valid && id_fpu && fgt1;
    waw  = id_valid && fgt1 && id_z_cls == 2'd2 && id_z == m_fp_z;
    m_stall  = (luse || fraw || fstr || waw) && !br_taken;
    m_flush  = br_taken;
    m_bubble = m_stall || br_taken;
    m_issue  = id_valid && !m_stall && !br_taken;
    if (rst) begin
      m_stall = 0; m_flush = 0; m_bubble = 0; m_busy = 0; m_issue = 0;
    end
  endtask

  task automatic tick;
    model_eval();
    if (rst) begin
      m_ld_t = -100; m_fp_t = -100; m_cnt = 0;
    end else begin
      if (m_stall && m_cnt < CMAX) m_cnt++;
      if (m_issue && id_ld)  begin m_ld_t = mt; m_ld_z = id_z; end
      if (m_issue && id_fpu) begin m_fp_t = mt; m_fp_z = id_z; end
    end
    mt++;
    @(posedge clk);
    #1;
  endtask

  task automatic setin(input logic v, input logic [3:0] y, input logic [1:0] yc,
                       input logic [3:0] x, input logic [1:0] xc,
                       input logic [3:0] z, input logic [1:0] zc,
                       input logic ld, input logic fpu, input logic br);
    id_valid = v; id_y = y; id_y_cls = yc; id_x = x; id_x_cls = xc;
    id_z = z; id_z_cls = zc; id_ld = ld; id_fpu = fpu; br_taken = br;
    #1;
  endtask

  task automatic idle;
    setin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset;
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  // Advance while the held ID instruction stalls; n = stall cycles, -1 on timeout.
  task automatic wait_issue(output int n);
    n = 0;
    while (stall === 1'b1 && n < 30) begin
      tick();
      n++;
    end
    if (n >= 30) n = -1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    setin(1, 4'd5, 2'd1, 4'd5, 2'd1, 4'd5, 2'd1, 1, 0, 1);
    tick();
    setin(1, 4'd5, 2'd1, 4'd5, 2'd1, 4'd5, 2'd1, 1, 0, 1);
    total++;
    if ({stall, bubble, flush, fpu_busy} !== 4'b0000) begin
      bad++; $display("FAIL reset_outs got=%b want=0000", {stall, bubble, flush, fpu_busy});
    end
    total++;
    if (stall_cnt !== '0) begin
      bad++; $display("FAIL reset_cnt got=%0d want=0", stall_cnt);
    end
    rst = 1'b0;
    idle();
    total++;
    if ({stall, bubble, flush, fpu_busy, stall_cnt} !== '0) begin
      bad++; $display("FAIL post_reset got=%b want=0", {stall, bubble, flush, fpu_busy, stall_cnt});
    end
  endtask

  task automatic test_load_use;
    do_reset();
    setin(1, 0, 0, 0, 0, 4'd5, 2'd1, 1, 0, 0);
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL lu_load_issue got=%b want=0", stall); end
    tick();
    setin(1, 4'd5, 2'd1, 0, 0, 4'd9, 2'd1, 0, 0, 0);
    total++;
    if ({stall, bubble} !== 2'b11) begin
      bad++; $display("FAIL lu_stall got=%b want=11", {stall, bubble});
    end
    tick();
    total++;
    if ({stall, bubble} !== 2'b00) begin
      bad++; $display("FAIL lu_release got=%b want=00", {stall, bubble});
    end
    total++;
    if (stall_cnt !== 4'd1) begin bad++; $display("FAIL lu_cnt got=%0d want=1", stall_cnt); end
    tick();
    idle();
  endtask

  task automatic test_fpu_raw;
    int n;
    do_reset();
    setin(1, 0, 0, 0, 0, 4'd3, 2'd2, 0, 1, 0);
    tick();
    setin(1, 0, 0, 4'd3, 2'd2, 4'd1, 2'd1, 0, 0, 0);
    wait_issue(n);
    total++;
    if (n !== LAT - 1) begin bad++; $display("FAIL fraw_cycles got=%0d want=%0d", n, LAT - 1); end
    total++;
    if (fpu_busy !== 1'b1) begin bad++; $display("FAIL fraw_busy_at1 got=%b want=1", fpu_busy); end
    tick();
    idle();
    total++;
    if (fpu_busy !== 1'b0) begin bad++; $display("FAIL fraw_busy_drop got=%b want=0", fpu_busy); end
    total++;
    if (stall_cnt !== 4'd3) begin bad++; $display("FAIL fraw_cnt got=%0d want=3", stall_cnt); end
  endtask

  task automatic test_fpu_struct_waw;
    int n;
    do_reset();
    setin(1, 0, 0, 0, 0, 4'd2, 2'd2, 0, 1, 0);
    tick();
    setin(1, 0, 0, 0, 0, 4'd7, 2'd2, 0, 1, 0);
    wait_issue(n);
    total++;
    if (n !== LAT - 1) begin bad++; $display("FAIL fstr_cycles got=%0d want=%0d", n, LAT - 1); end
    tick();
    idle();
    for (int i = 0; i < 10 && fpu_busy; i++) tick();
    setin(1, 0, 0, 0, 0, 4'd2, 2'd2, 0, 1, 0);
    tick();
    setin(1, 0, 0, 0, 0, 4'd2, 2'd2, 0, 0, 0);
    wait_issue(n);
    total++;
    if (n !== LAT - 1) begin bad++; $display("FAIL waw_cycles got=%0d want=%0d", n, LAT - 1); end
    tick();
    idle();
  endtask

  task automatic test_branch;
    do_reset();
    setin(1, 0, 0, 0, 0, 4'd5, 2'd1, 1, 0, 0);
    tick();
    setin(1, 4'd5, 2'd1, 0, 0, 4'd6, 2'd1, 0, 0, 1);
    total++;
    if ({flush, stall, bubble} !== 3'b101) begin
      bad++; $display("FAIL br_prio got=%b want=101", {flush, stall, bubble});
    end
    tick();
    setin(1, 4'd5, 2'd1, 0, 0, 4'd6, 2'd1, 0, 0, 0);
    total++;
    if ({flush, stall, bubble} !== 3'b000) begin
      bad++; $display("FAIL br_after got=%b want=000", {flush, stall, bubble});
    end
    total++;
    if (stall_cnt !== 4'd0) begin bad++; $display("FAIL br_cnt got=%0d want=0", stall_cnt); end
    tick();
    idle();
  endtask

  task automatic test_class_mismatch;
    logic [1:0] cls [2];
    cls[0] = 2'd3;
    cls[1] = 2'd2;
    for (int i = 0; i < 2; i++) begin
      do_reset();
      setin(1, 0, 0, 0, 0, 4'd5, 2'd1, 1, 0, 0);
      tick();
      setin(1, 4'd5, cls[i], 4'd5, 2'd0, 4'd8, 2'd1, 0, 0, 0);
      total++;
      if (stall !== 1'b0) begin bad++; $display("FAIL cls_mismatch%0d got=%b want=0", i, stall); end
      tick();
      idle();
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    setin(1, 0, 0, 0, 0, 4'd3, 2'd2, 0, 1, 0);
    tick();
    idle();
    tick();
    total++;
    if (fpu_busy !== 1'b1) begin bad++; $display("FAIL rmid_busy got=%b want=1", fpu_busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    setin(1, 0, 0, 4'd3, 2'd2, 4'd1, 2'd2, 0, 1, 0);
    total++;
    if ({stall, fpu_busy} !== 2'b00) begin
      bad++; $display("FAIL rmid_nostall got=%b want=00", {stall, fpu_busy});
    end
    tick();
    idle();
  endtask

  task automatic test_saturation;
    int n;
    do_reset();
    for (int r = 0; r < 7; r++) begin
      setin(1, 0, 0, 0, 0, 4'd3, 2'd2, 0, 1, 0);
      tick();
      setin(1, 0, 0, 4'd3, 2'd2, 4'd1, 2'd1, 0, 0, 0);
      wait_issue(n);
      if (n < 0) begin
        total++; bad++; $display("FAIL sat_timeout round=%0d", r);
      end
      tick();
      if (r == 4) begin
        total++;
        if (stall_cnt !== 4'd15) begin bad++; $display("FAIL sat_reach got=%0d want=15", stall_cnt); end
      end
    end
    idle();
    total++;
    if (stall_cnt !== 4'd15) begin bad++; $display("FAIL sat_hold got=%0d want=15", stall_cnt); end
  endtask

  task automatic test_random;
    logic ld, fpu;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 60) == 0);
      ld  = ($urandom_range(0, 3) == 0);
      fpu = !ld && ($urandom_range(0, 2) == 0);
      setin($urandom_range(0, 5) != 0,
            4'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            4'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            4'($urandom_range(0, 3)),
            ld ? 2'd1 : (fpu ? 2'd2 : 2'($urandom_range(0, 3))),
            ld, fpu, $urandom_range(0, 7) == 0);
      model_eval();
      total++;
      if ({stall, bubble, flush, fpu_busy} !== {m_stall, m_bubble, m_flush, m_busy}) begin
        bad++;
        $display("FAIL rand_outs cyc=%0d got=%b want=%b", i,
                 {stall, bubble, flush, fpu_busy}, {m_stall, m_bubble, m_flush, m_busy});
      end
      total++;
      if (stall_cnt !== (rst ? 4'd0 : 4'(m_cnt))) begin
        bad++; $display("FAIL rand_cnt cyc=%0d got=%0d want=%0d", i, stall_cnt, rst ? 0 : m_cnt);
      end
      tick();
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_fpu_raw();
    test_fpu_struct_waw();
    test_branch();
    test_class_mismatch();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
